// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide data memory.
// One request in flight at a time. Byte and halfword stores use a read
// followed by a merged full-word write. Misaligned or out-of-range
// requests are rejected without touching memory.
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqPC,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [2:0]  ReqOp,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespExc,
  output logic [31:0] MemPC,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic        MemWriteEnable,
  input  logic [31:0] MemReadData
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  op_r;
  logic        resp_valid_r;
  logic        resp_exc_r;
  logic [31:0] resp_data_r;
  logic [31:0] mem_data_r;
  logic        we_r;
  logic        req_exc_s;

  // Alignment rule: words need Addr[1:0]==0, halfwords need Addr[0]==0.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic bad;
    case (op)
      OP_LW, OP_SW:         bad = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = lo[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Select the addressed little-endian lane and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (op)
      OP_LW:   r = word;
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h00_0000, b};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the read word; other lanes pass through.
  function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] word, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (op)
      OP_SB:   r[{lo, 3'b000} +: 8]    = wdata[7:0];
      OP_SH:   r[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = word;
    endcase
    return r;
  endfunction

  // Reject check on the incoming request, evaluated before any memory access.
  always_comb begin
    req_exc_s = is_misaligned(ReqOp, ReqAddr[1:0]) | (ReqAddr >= ADDR_LIMIT);
  end

  // Reset also gates ready and the write strobe so a reset mid-WRITE never commits.
  assign ReqReady       = (state_r == IDLE) & ~reset;
  assign MemWriteEnable = we_r & ~reset;
  assign MemAddr        = {addr_r[31:2], 2'b00};
  assign MemPC          = pc_r;
  assign MemData        = mem_data_r;
  assign RespValid      = resp_valid_r;
  assign RespExc        = resp_exc_r;
  assign RespData       = resp_data_r;

  // Request FSM: latch on accept, optional read, optional write, one-cycle response.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pc_r         <= 32'h0000_0000;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      op_r         <= 3'd0;
      resp_valid_r <= 1'b0;
      resp_exc_r   <= 1'b0;
      resp_data_r  <= 32'h0000_0000;
      mem_data_r   <= 32'h0000_0000;
      we_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ReqValid) begin
            pc_r    <= ReqPC;
            addr_r  <= ReqAddr;
            wdata_r <= ReqWData;
            op_r    <= ReqOp;
            if (req_exc_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_exc_r   <= 1'b1;
              resp_data_r  <= 32'h0000_0000;
            end else if (ReqOp == OP_SW) begin
              state_r    <= WRITE;
              we_r       <= 1'b1;
              mem_data_r <= ReqWData;
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if ((op_r == OP_SH) || (op_r == OP_SB)) begin
            mem_data_r <= store_merge(op_r, addr_r[1:0], MemReadData, wdata_r);
            we_r       <= 1'b1;
            state_r    <= WRITE;
          end else begin
            resp_data_r  <= load_extend(op_r, addr_r[1:0], MemReadData);
            resp_valid_r <= 1'b1;
            resp_exc_r   <= 1'b0;
            state_r      <= RESP;
          end
        end
        WRITE: begin
          we_r         <= 1'b0;
          resp_valid_r <= 1'b1;
          resp_exc_r   <= 1'b0;
          resp_data_r  <= 32'h0000_0000;
          state_r      <= RESP;
        end
        RESP: begin
          resp_valid_r <= 1'b0;
          resp_exc_r   <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          we_r         <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_exc_r   <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_LIMIT, default 32'h0000_1000, meaning the first byte address outside data memory (4 KiB, 1024 words).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 Port Clk  in  1  sole clock; all state updates on posedge Clk.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port ReqValid  in  1  request present.
REQ-006 Port ReqReady  out  1  unit can accept a request this cycle.
REQ-007 Port ReqPC  in  32  PC of the issuing instruction.
REQ-008 Port ReqAddr  in  32  byte address.
REQ-009 Port ReqWData  in  32  store data; sub-word data is taken from the low bits.
REQ-010 Port ReqOp  in  3  operation select: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-011 Port RespValid  out  1  one-cycle completion pulse.
REQ-012 Port RespData  out  32  load result, extended to 32 bits.
REQ-013 Port RespExc  out  1  request rejected (misaligned or out of range).
REQ-014 Port MemPC  out  32  PC forwarded to data memory for its write log.
REQ-015 Port MemAddr  out  32  word-aligned address to data memory; bits [1:0] are always 0.
REQ-016 Port MemData  out  32  write word to data memory.
REQ-017 Port MemWriteEnable  out  1  data memory write strobe; memory writes on the posedge where it is 1.
REQ-018 Port MemReadData  in  32  combinational read of the word at MemAddr.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WRITE and RESP; ReqReady SHALL be 1 only in IDLE with reset low.
REQ-020 In IDLE, when ReqValid=1, the block SHALL latch ReqPC, ReqAddr, ReqWData and ReqOp, then go to the next state as follows:
- exception -> RESP;
- loads, SH, SB -> READ;
- SW -> WRITE.
ReqValid SHALL be ignored in every state other than IDLE.
REQ-021 An exception SHALL be raised in any of these cases:
- LW or SW with Addr[1:0]!=0;
- LH, LHU or SH with Addr[0]!=0;
- Addr >= ADDR_LIMIT.
On an exception no memory write occurs, and RESP drives RespExc=1 with RespData=0.
REQ-022 READ SHALL last exactly one cycle, and MemReadData SHALL be registered at its end. From READ, loads go to RESP and SH/SB go to WRITE.
REQ-023 WRITE SHALL assert MemWriteEnable=1 for exactly one cycle and then go to RESP; MemWriteEnable SHALL be 0 in every other state.
REQ-024 Byte lanes SHALL be little-endian:
- byte k = word[8k+7:8k], with k=Addr[1:0];
- halfword h = word[16h+15:16h], with h=Addr[1].
REQ-025 Load extension: LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL return the word unchanged.
REQ-026 SH and SB SHALL be performed as read-modify-write:
- MemData = registered read word with only the addressed lane replaced by ReqWData[7:0] or [15:0];
- all other lanes are preserved bit-exact.
REQ-027 For SW, MemData SHALL equal the latched ReqWData.
REQ-028 MemAddr SHALL equal {latched Addr[31:2], 2'b00} in READ and WRITE; MemPC SHALL equal the latched PC.
REQ-029 RESP SHALL assert RespValid=1 for exactly one cycle, then return to IDLE. RespData SHALL be the load result for loads and 0 for stores.
REQ-030 Latency, measured from the accept edge (cycle 0) to the cycle in which RespValid=1:
- LW/LH/LHU/LB/LBU: 2 cycles;
- SW: 2 cycles;
- SH/SB: 3 cycles;
- exception: 1 cycle.
REQ-031 Back-to-back requests: a new request SHALL be accepted in the cycle after RESP. At most one request is in flight.
REQ-032 Address wrap: no address arithmetic is performed; only bits [11:2] select a memory word, and the range check of REQ-021 runs before any access.

Reset
REQ-033 While reset=1, the block SHALL go to IDLE at the next posedge.
REQ-034 Values at that posedge:
- RespValid=0, RespExc=0, RespData=0;
- MemAddr=0, MemData=0, MemPC=0;
- all latched request fields = 0.
REQ-035 MemWriteEnable SHALL be forced to 0 whenever reset=1, including mid-WRITE, so that no partial RMW commits.
REQ-036 ReqReady SHALL be 0 while reset=1, and 1 in the first cycle after reset deasserts.
REQ-037 A request in flight during reset SHALL be dropped with no response.

Verification
REQ-038 SW Addr=0x10, Data=0xDEADBEEF, PC=0x3000 -> MemWriteEnable for 1 cycle with MemAddr=0x10, MemData=0xDEADBEEF, MemPC=0x3000; RespValid 2 cycles after accept.
REQ-039 Word 0x10 = 0x11223344; SB Addr=0x12, Data=0xAA -> MemData=0x11AA3344; then LB 0x12 -> RespData=0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
REQ-040 Word 0x20 = 0x8001_7FFF; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; SH 0x20, Data=0x1234 -> memory word 0x80011234.
REQ-041 LW 0x13, SH 0x21 and SW 0x1000 -> each gives RespExc=1 one cycle after accept with MemWriteEnable never 1; ReqValid held high during the busy cycles is not double-accepted.
REQ-042 Issue SB, assert reset in its WRITE cycle -> MemWriteEnable=0, memory word unchanged, no RespValid; ReqReady=1 in the cycle after reset drops.
